// File: rtl/usb2_ts_ep_packer.sv
// Packs a free-running MPEG-TS byte stream into whole 188-byte packets in the
// isochronous endpoint's input buffer. It commits when the buffer is full, on an
// idle timeout, or when capture is disabled.
module usb2_ts_ep_packer #(
    parameter int PKT_LEN         = 188,
    parameter int PKTS_PER_COMMIT = 5,
    parameter int FLUSH_TIMEOUT   = 8192,
    parameter int CNT_W           = 16
) (
    input  logic             phy_clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [7:0]       ts_data,
    input  logic             ts_valid,
    input  logic             ts_sop,
    output logic [10:0]      buf_in_addr,
    output logic [7:0]       buf_in_data,
    output logic             buf_in_wren,
    input  logic             buf_in_ready,
    output logic             buf_in_commit,
    output logic [10:0]      buf_in_commit_len,
    input  logic             buf_in_commit_ack,
    output logic [CNT_W-1:0] drop_count,
    output logic [CNT_W-1:0] sync_err_count,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    localparam int NP_W   = $clog2(PKTS_PER_COMMIT + 1);
    localparam int IDLE_W = $clog2(FLUSH_TIMEOUT);
    localparam int BI_W   = $clog2(PKT_LEN);

    typedef enum logic [1:0] {
        WAIT_READY = 2'd0,
        FILL       = 2'd1,
        COMMIT     = 2'd2
    } state_t;

    state_t            state, state_d;
    logic [10:0]       wr_ptr, wr_ptr_d, pkt_base, pkt_base_d;
    logic [BI_W-1:0]   byte_idx, byte_idx_d;
    logic [NP_W-1:0]   npkts, npkts_d, npkts_inc;
    logic [IDLE_W-1:0] idle_cnt, idle_d;
    logic              in_pkt, in_pkt_d;
    logic              wren_d, commit_d, drop_inc, sync_inc;
    logic [10:0]       addr_d, len_d;
    logic [7:0]        data_d;
    logic              pkt_start, bad_sop;

    function automatic logic [10:0] len_of(input logic [NP_W-1:0] n);
        return 11'(n) * 11'(PKT_LEN);
    endfunction

    assign pkt_start = ts_valid & ts_sop & (ts_data == 8'h47);
    assign bad_sop   = ts_valid & ts_sop & (ts_data != 8'h47);
    assign npkts_inc = npkts + NP_W'(1);
    assign busy      = (state != WAIT_READY);
    assign dbg_state = state;

    always_comb begin
        state_d    = state;
        wr_ptr_d   = wr_ptr;
        pkt_base_d = pkt_base;
        byte_idx_d = byte_idx;
        npkts_d    = npkts;
        idle_d     = idle_cnt;
        in_pkt_d   = in_pkt;
        wren_d     = 1'b0;
        addr_d     = buf_in_addr;
        data_d     = buf_in_data;
        commit_d   = buf_in_commit;
        len_d      = buf_in_commit_len;
        drop_inc   = 1'b0;
        sync_inc   = bad_sop;
        case (state)
            WAIT_READY: begin
                // A packet arriving while no buffer is open is lost whole, even on the opening cycle.
                drop_inc = pkt_start;
                if (enable && buf_in_ready && !buf_in_commit_ack) begin
                    state_d    = FILL;
                    wr_ptr_d   = '0;
                    pkt_base_d = '0;
                    npkts_d    = '0;
                    byte_idx_d = '0;
                    idle_d     = '0;
                    in_pkt_d   = 1'b0;
                end
            end
            FILL: begin
                if (in_pkt) begin
                    if (pkt_start) begin
                        // Resync: discard the partial packet and restart it in place.
                        sync_inc   = 1'b1;
                        wren_d     = 1'b1;
                        addr_d     = pkt_base;
                        data_d     = ts_data;
                        wr_ptr_d   = pkt_base + 11'd1;
                        byte_idx_d = BI_W'(1);
                    end else if (ts_valid && !ts_sop) begin
                        wren_d     = 1'b1;
                        addr_d     = wr_ptr;
                        data_d     = ts_data;
                        wr_ptr_d   = wr_ptr + 11'd1;
                        byte_idx_d = byte_idx + 1'b1;
                        if (byte_idx == BI_W'(PKT_LEN - 1)) begin
                            in_pkt_d   = 1'b0;
                            npkts_d    = npkts_inc;
                            pkt_base_d = wr_ptr + 11'd1;
                            idle_d     = '0;
                            if (npkts_inc == NP_W'(PKTS_PER_COMMIT)) begin
                                state_d  = COMMIT;
                                commit_d = 1'b1;
                                len_d    = len_of(npkts_inc);
                            end
                        end
                    end
                end else if (!enable) begin
                    drop_inc = pkt_start;
                    if (npkts == '0) begin
                        state_d = WAIT_READY;
                    end else begin
                        state_d  = COMMIT;
                        commit_d = 1'b1;
                        len_d    = len_of(npkts);
                    end
                end else if (pkt_start) begin
                    wren_d     = 1'b1;
                    addr_d     = wr_ptr;
                    data_d     = ts_data;
                    wr_ptr_d   = wr_ptr + 11'd1;
                    byte_idx_d = BI_W'(1);
                    in_pkt_d   = 1'b1;
                end else if (npkts != '0) begin
                    idle_d = idle_cnt + 1'b1;
                    if (idle_cnt == IDLE_W'(FLUSH_TIMEOUT - 1)) begin
                        state_d  = COMMIT;
                        commit_d = 1'b1;
                        len_d    = len_of(npkts);
                    end
                end
            end
            COMMIT: begin
                drop_inc = pkt_start;
                if (buf_in_commit_ack) begin
                    commit_d = 1'b0;
                    state_d  = WAIT_READY;
                end
            end
            default: state_d = WAIT_READY;
        endcase
    end

    always_ff @(posedge phy_clk or posedge reset) begin
        if (reset) begin
            state <= WAIT_READY;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge phy_clk or posedge reset) begin
        if (reset) begin
            wr_ptr            <= '0;
            pkt_base          <= '0;
            byte_idx          <= '0;
            npkts             <= '0;
            idle_cnt          <= '0;
            in_pkt            <= 1'b0;
            buf_in_wren       <= 1'b0;
            buf_in_addr       <= '0;
            buf_in_data       <= '0;
            buf_in_commit     <= 1'b0;
            buf_in_commit_len <= '0;
            drop_count        <= '0;
            sync_err_count    <= '0;
        end else begin
            wr_ptr            <= wr_ptr_d;
            pkt_base          <= pkt_base_d;
            byte_idx          <= byte_idx_d;
            npkts             <= npkts_d;
            idle_cnt          <= idle_d;
            in_pkt            <= in_pkt_d;
            buf_in_wren       <= wren_d;
            buf_in_addr       <= addr_d;
            buf_in_data       <= data_d;
            buf_in_commit     <= commit_d;
            buf_in_commit_len <= len_d;
            if (drop_inc && drop_count != '1) drop_count <= drop_count + 1'b1;
            if (sync_inc && sync_err_count != '1) sync_err_count <= sync_err_count + 1'b1;
        end
    end

endmodule

// File: doc/usb2_ts_ep_packer.md
Name: usb2_ts_ep_packer

Overview:
- Sequences the isochronous TS-to-host endpoint's input buffer (EP3 buf_in interface: addr/data/wren/ready/commit/commit_len/commit_ack).
- Takes a free-running MPEG-TS byte stream from the demod capture path and writes whole 188-byte packets into the endpoint buffer.
- Commits the buffer once PKTS_PER_COMMIT packets are stored, or on an idle-timeout flush.
- The input has no backpressure, so packets that cannot be stored are dropped whole and counted.

Parameters:
- PKT_LEN, 188, TS packet length in bytes.
- PKTS_PER_COMMIT, 5, packets per full commit (5*188 = 940, must be ≤ 1024).
- FLUSH_TIMEOUT, 8192, idle cycles after the last completed packet before a partial commit.
- CNT_W, 16, width of the statistics counters.

Ports:
- phy_clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  capture enable.
- ts_data  in  8  TS byte.
- ts_valid  in  1  ts_data is valid this cycle.
- ts_sop  in  1  start of packet, qualified by ts_valid.
- buf_in_addr  out  11  endpoint buffer write address.
- buf_in_data  out  8  endpoint buffer write data.
- buf_in_wren  out  1  endpoint buffer write strobe.
- buf_in_ready  in  1  endpoint buffer is free to fill.
- buf_in_commit  out  1  commit request.
- buf_in_commit_len  out  11  committed byte count.
- buf_in_commit_ack  in  1  commit accepted.
- drop_count  out  CNT_W  packets dropped because no buffer was available.
- sync_err_count  out  CNT_W  sync errors.
- busy  out  1  high in any state except WAIT_READY.

Behaviour:
- Reset (async): state=WAIT_READY; all outputs 0; wr_ptr, pkt_base, byte_idx, npkts, idle_cnt, in_pkt all 0. Reset mid-fill abandons the buffer with no commit.
- Write port is registered. An accepted byte at cycle N produces wren=1 with addr/data at N+1. wren is a 1-cycle pulse per byte; addr/data hold their last value otherwise.
- Packet start: the byte has ts_valid & ts_sop & ts_data==8'h47.
- States:
  - WAIT_READY: leave when enable & buf_in_ready & ~buf_in_commit_ack. Go to FILL with wr_ptr=pkt_base=npkts=0.
  - FILL:
    - Packet start while ~in_pkt: write byte at wr_ptr, in_pkt=1, byte_idx=1.
    - Valid non-sop byte while in_pkt: write at wr_ptr, wr_ptr++, byte_idx++.
    - On the write with byte_idx==PKT_LEN-1: packet complete. in_pkt=0, npkts++, pkt_base=wr_ptr+1, idle_cnt=0.
    - If npkts reaches PKTS_PER_COMMIT: go to COMMIT.
  - FILL with ~in_pkt & npkts≥1:
    - idle_cnt increments each cycle. At FLUSH_TIMEOUT-1 go to COMMIT.
    - enable=0 also goes to COMMIT next cycle.
  - FILL with ~in_pkt & npkts==0 & enable=0: go to WAIT_READY.
  - enable=0 while in_pkt: the current packet completes normally first.
  - COMMIT: buf_in_commit=1, buf_in_commit_len=npkts*PKT_LEN, both held stable. When buf_in_commit_ack is sampled 1, drop commit the next cycle and go to WAIT_READY.
- Sync errors: sync_err_count increments once per event.
  - ts_sop with data≠8'h47 in any state: byte ignored.
  - Packet start while in_pkt in FILL: wr_ptr rewinds to pkt_base, the partial packet is discarded, and the new packet starts at pkt_base in the same cycle.
- Valid bytes with ~in_pkt and no packet start are ignored silently.
- Drops: a packet start seen in WAIT_READY or COMMIT increments drop_count. The rest of that packet is ignored. The state stays non-fill until the next accepted packet start in FILL.
- Simultaneous events:
  - Packet start on the cycle WAIT_READY→FILL is taken: it is dropped.
  - The final byte completing packet N in FILL wins over the timeout.
- Counters saturate at all-ones.
- commit_len width: max PKTS_PER_COMMIT*PKT_LEN must fit 11 bits.

Test Plan:
- ready=1; stream 5 clean packets back-to-back:
  - Expect 940 wren pulses, addrs 0..939.
  - Expect commit with len=940 held until ack.
  - Pulse ack → commit low next cycle, busy=0 once back in WAIT_READY.
- 2 packets then ts_valid=0 for FLUSH_TIMEOUT cycles → commit with len=376. No commit at FLUSH_TIMEOUT-2.
- Sop at byte 100 of packet 2:
  - sync_err_count=1.
  - Next packet written starting at addr 188.
  - 5 full packets still commit with len=940.
- Hold buf_in_ready=0, stream 3 packets → drop_count=3, no wren. Then ready=1 → next packet written at addr 0.
- Sop with data 8'h00 → sync_err_count=1, no write.
- Assert reset at byte 50 of packet 3 → all outputs 0 immediately, no commit. After release, refill starts at addr 0.
- enable deasserted mid-packet 2 → packet 2 finishes, then commit with len=376.
